link_tx_responder: RTL and testbench
====================================

LINK_TX_RESPONDER -- requirements
Module: link_tx_responder

Interface
REQ-001 Parameter BYTE_CYC, default 1: clock cycles per transmitted byte slot, legal range 1..15.
REQ-002 Parameter IFG, default 12: inter-frame gap in cycles, legal range 1..255.
REQ-003 Parameter GO_TIMEOUT, default 16: maximum cycles granted without go, legal range 1..255.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 bool_ready  input  1  requester holds a packet.
REQ-007 bool_go  input  1  requester starts a packet (1-cycle pulse).
REQ-008 pkt_len  input  8  packet length in bytes, sampled when bool_go=1.
REQ-009 ena_n  output  1  active-low grant to requester.
REQ-010 link_busy  output  1  high while a byte is being sent.
REQ-011 byte_strobe  output  1  one-cycle pulse per completed byte slot.
REQ-012 tx_done  output  1  one-cycle pulse on last byte of a packet.
REQ-013 timeout_err  output  1  one-cycle pulse when a grant expires without go.
REQ-014 pkt_cnt  output  16  count of completed packets.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, GRANT, XMIT and GAP, all outputs registered.
REQ-016 IDLE: ena_n=1; bool_ready=1 -> GRANT next cycle, ena_n=0 one cycle after ready is seen.
REQ-017 GRANT: ena_n=0; an 8-bit wait counter starts at 0 on entry and increments each cycle.
REQ-018 GRANT, bool_go=1 and pkt_len!=0: latch pkt_len into a remaining-byte counter and go to XMIT; go takes priority over withdraw or timeout in the same cycle.
REQ-019 GRANT, bool_go=1 and pkt_len=0: go to GAP; no tx_done, no pkt_cnt change.
REQ-020 GRANT, bool_ready=0 and bool_go=0: withdraw to IDLE; ena_n=1 next cycle; no error.
REQ-021 GRANT, wait counter = GO_TIMEOUT-1 with no go: pulse timeout_err, go to IDLE.
REQ-022 XMIT: ena_n=0, link_busy=1; byte_strobe pulses every BYTE_CYC cycles; remaining-byte counter decrements on each strobe.
REQ-023 XMIT duration SHALL be exactly pkt_len*BYTE_CYC cycles, with the first strobe BYTE_CYC cycles after entry.
REQ-024 On the strobe that takes the remaining count to 0: tx_done=1 in the same cycle, pkt_cnt+1, enter GAP next cycle.
REQ-025 bool_go and bool_ready SHALL be ignored in XMIT and GAP.
REQ-026 GAP: ena_n=1, link_busy=0 for exactly IFG cycles, then IDLE.
REQ-027 pkt_cnt SHALL wrap from 16'hFFFF to 16'h0000.
REQ-028 With bool_ready held high, the next grant SHALL occur one cycle after GAP ends; back-to-back packets need no extra handshake.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, ena_n=1, link_busy=0, byte_strobe=0, tx_done=0, timeout_err=0, pkt_cnt=0, and clear all internal counters.
REQ-030 rst during XMIT SHALL abort the packet with no tx_done and no pkt_cnt increment; operation resumes from IDLE on the first edge with rst=0.

Verification
REQ-031 Defaults; ready=1, go one cycle after ena_n falls, pkt_len=4 -> 4 consecutive byte_strobe pulses, tx_done on the 4th, pkt_cnt=1, ena_n=1 for 12 cycles.
REQ-032 BYTE_CYC=3, pkt_len=2 -> strobes 3 and 6 cycles after XMIT entry; link_busy high for 6 cycles.
REQ-033 ready=1 with go never asserted -> timeout_err pulses 16 cycles after ena_n falls; IDLE follows, then re-grant since ready is still 1.
REQ-034 go with pkt_len=0 -> no strobe, no tx_done, pkt_cnt unchanged, 12-cycle GAP.
REQ-035 rst asserted at the 2nd strobe of an 8-byte packet -> all outputs at reset values next cycle; a later 1-byte packet gives pkt_cnt=1.
REQ-036 Preload of 65535 completed 1-byte packets, then one more -> pkt_cnt=0; ready dropped in GRANT -> IDLE with no timeout_err.

Source files
------------

// File: rtl/link_tx_responder.sv
// link_tx_responder
// Grants a link to a single requester, then paces the transmission of the
// requester's packet. Each byte takes a fixed number of cycles. An
// inter-frame gap follows every packet. A grant that is not used in time
// is revoked.
//
// Parameters
//   BYTE_CYC    cycles per byte slot (1..15)
//   IFG         inter-frame gap length in cycles (1..255)
//   GO_TIMEOUT  cycles a grant may stay unused (1..255)
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   bool_ready   requester holds a packet
//   bool_go      requester starts its packet (single-cycle pulse)
//   pkt_len      packet length in bytes, sampled with bool_go
//   ena_n        active-low grant to the requester
//   link_busy    high while bytes are being sent
//   byte_strobe  pulse per completed byte slot
//   tx_done      pulse together with the strobe of the final byte
//   timeout_err  pulse when a grant expires without go
//   pkt_cnt      wrapping count of completed packets
module link_tx_responder #(
  parameter int BYTE_CYC   = 1,
  parameter int IFG        = 12,
  parameter int GO_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bool_ready,
  input  logic        bool_go,
  input  logic [7:0]  pkt_len,
  output logic        ena_n,
  output logic        link_busy,
  output logic        byte_strobe,
  output logic        tx_done,
  output logic        timeout_err,
  output logic [15:0] pkt_cnt
);

  localparam logic [3:0] SLOT_LAST = 4'(BYTE_CYC - 1);
  localparam logic [7:0] GAP_LAST  = 8'(IFG - 1);
  localparam logic [7:0] WAIT_LAST = 8'(GO_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, XMIT, GAP} state_t;

  state_t      state_reg;
  logic [7:0]  wait_reg;    // cycles spent in GRANT
  logic [7:0]  rem_reg;     // bytes still to send
  logic [3:0]  slot_reg;    // cycle position inside the current byte slot
  logic [7:0]  gap_reg;     // cycles spent in GAP
  logic        ena_n_reg;
  logic        link_busy_reg;
  logic        byte_strobe_reg;
  logic        tx_done_reg;
  logic        timeout_err_reg;
  logic [15:0] pkt_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      wait_reg        <= '0;
      rem_reg         <= '0;
      slot_reg        <= '0;
      gap_reg         <= '0;
      ena_n_reg       <= 1'b1;
      link_busy_reg   <= 1'b0;
      byte_strobe_reg <= 1'b0;
      tx_done_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
      pkt_cnt_reg     <= '0;
    end else begin
      // Pulse outputs default low and are raised only for a single cycle.
      byte_strobe_reg <= 1'b0;
      tx_done_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bool_ready) begin
            state_reg <= GRANT;
            ena_n_reg <= 1'b0;
            wait_reg  <= '0;
          end
        end
        GRANT: begin
          // go wins over withdraw and over timeout in the same cycle.
          if (bool_go) begin
            if (pkt_len != 8'd0) begin
              state_reg     <= XMIT;
              rem_reg       <= pkt_len;
              slot_reg      <= '0;
              link_busy_reg <= 1'b1;
            end else begin
              // An empty packet still costs a full inter-frame gap.
              state_reg <= GAP;
              gap_reg   <= '0;
              ena_n_reg <= 1'b1;
            end
          end else if (!bool_ready) begin
            state_reg <= IDLE;
            ena_n_reg <= 1'b1;
          end else if (wait_reg == WAIT_LAST) begin
            state_reg       <= IDLE;
            ena_n_reg       <= 1'b1;
            timeout_err_reg <= 1'b1;
          end else begin
            wait_reg <= wait_reg + 8'd1;
          end
        end
        XMIT: begin
          if (slot_reg == SLOT_LAST) begin
            slot_reg        <= '0;
            byte_strobe_reg <= 1'b1;
            rem_reg         <= rem_reg - 8'd1;
            // The final strobe lands in the first GAP cycle, so link_busy
            // covers exactly pkt_len*BYTE_CYC cycles.
            if (rem_reg == 8'd1) begin
              tx_done_reg   <= 1'b1;
              pkt_cnt_reg   <= pkt_cnt_reg + 16'd1;
              state_reg     <= GAP;
              gap_reg       <= '0;
              link_busy_reg <= 1'b0;
              ena_n_reg     <= 1'b1;
            end
          end else begin
            slot_reg <= slot_reg + 4'd1;
          end
        end
        GAP: begin
          if (gap_reg == GAP_LAST) begin
            state_reg <= IDLE;
          end else begin
            gap_reg <= gap_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ena_n       = ena_n_reg;
  assign link_busy   = link_busy_reg;
  assign byte_strobe = byte_strobe_reg;
  assign tx_done     = tx_done_reg;
  assign timeout_err = timeout_err_reg;
  assign pkt_cnt     = pkt_cnt_reg;

endmodule

// File: tb/tb_link_tx_responder.sv
// Directed testbench for link_tx_responder. One instance uses the default
// parameters. A second instance uses BYTE_CYC=3 to exercise multi-cycle
// byte slots.
module tb_link_tx_responder;

  localparam int IFG_T = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        ena_n, link_busy, byte_strobe, tx_done, timeout_err;
  logic [15:0] pkt_cnt;

  logic        ready3 = 1'b0;
  logic        go3 = 1'b0;
  logic [7:0]  len3 = 8'd0;
  logic        ena_n3, link_busy3, byte_strobe3, tx_done3, timeout_err3;
  logic [15:0] pkt_cnt3;

  int checks = 0;
  int errors = 0;
  int seen;

  always #5 clk = ~clk;

  link_tx_responder dut (
    .clk(clk), .rst(rst), .bool_ready(ready), .bool_go(go), .pkt_len(len),
    .ena_n(ena_n), .link_busy(link_busy), .byte_strobe(byte_strobe),
    .tx_done(tx_done), .timeout_err(timeout_err), .pkt_cnt(pkt_cnt)
  );

  link_tx_responder #(.BYTE_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .bool_ready(ready3), .bool_go(go3), .pkt_len(len3),
    .ena_n(ena_n3), .link_busy(link_busy3), .byte_strobe(byte_strobe3),
    .tx_done(tx_done3), .timeout_err(timeout_err3), .pkt_cnt(pkt_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ena_n"}, 32'(ena_n), 32'd1);
    check({tag, "_busy"}, 32'(link_busy), 32'd0);
    check({tag, "_strobe"}, 32'(byte_strobe), 32'd0);
    check({tag, "_done"}, 32'(tx_done), 32'd0);
    check({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    check({tag, "_cnt"}, 32'(pkt_cnt), 32'd0);
  endtask

  // Entered with the first GAP cycle already sampled. The remaining GAP
  // cycles come next, then a single IDLE cycle. The grant is back after
  // that while ready stays high.
  task automatic gap_then_grant(input string tag);
    for (int i = 1; i < IFG_T; i++) begin
      step();
      check({tag, "_gap_ena_n"}, 32'(ena_n), 32'd1);
      check({tag, "_gap_busy"}, 32'(link_busy), 32'd0);
      check({tag, "_gap_strobe"}, 32'(byte_strobe | tx_done), 32'd0);
    end
    step();
    check({tag, "_idle_ena_n"}, 32'(ena_n), 32'd1);
    step();
    check({tag, "_regrant"}, 32'(ena_n), 32'd0);
  endtask

  initial begin
    // Reset
    step();
    step();
    check_reset("reset");
    rst = 1'b0;
    ready = 1'b1;
    step();
    check("grant_after_ready", 32'(ena_n), 32'd0);

    // 4-byte packet with default parameters
    go = 1'b1; len = 8'd4;
    step();
    go = 1'b0;
    check("xmit_busy", 32'(link_busy), 32'd1);
    check("xmit_no_strobe_at_entry", 32'(byte_strobe), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("p4_strobe%0d", i), 32'(byte_strobe), 32'd1);
      check($sformatf("p4_done%0d", i), 32'(tx_done), (i == 3) ? 32'd1 : 32'd0);
      check($sformatf("p4_busy%0d", i), 32'(link_busy), (i == 3) ? 32'd0 : 32'd1);
    end
    check("p4_cnt", 32'(pkt_cnt), 32'd1);
    check("p4_gap_ena_n", 32'(ena_n), 32'd1);
    gap_then_grant("p4");

    // Grant never used: timeout 16 cycles after ena_n fell, then re-grant
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (timeout_err) begin
        seen = k;
        break;
      end
    end
    check("timeout_latency", 32'(seen), 32'd16);
    check("timeout_ena_n", 32'(ena_n), 32'd1);
    step();
    check("timeout_pulse_width", 32'(timeout_err), 32'd0);
    check("timeout_regrant", 32'(ena_n), 32'd0);

    // Zero-length packet
    go = 1'b1; len = 8'd0;
    step();
    go = 1'b0;
    check("p0_ena_n", 32'(ena_n), 32'd1);
    check("p0_busy", 32'(link_busy), 32'd0);
    check("p0_strobe", 32'(byte_strobe | tx_done), 32'd0);
    check("p0_cnt", 32'(pkt_cnt), 32'd1);
    gap_then_grant("p0");
    check("p0_cnt_after", 32'(pkt_cnt), 32'd1);

    // Reset lands on the edge of the 2nd strobe of an 8-byte packet
    go = 1'b1; len = 8'd8;
    step();
    go = 1'b0;
    step();
    check("p8_strobe1", 32'(byte_strobe), 32'd1);
    rst = 1'b1;
    step();
    check_reset("abort");
    rst = 1'b0;
    step();
    check("abort_regrant", 32'(ena_n), 32'd0);
    go = 1'b1; len = 8'd1;
    step();
    go = 1'b0;
    check("p1_busy", 32'(link_busy), 32'd1);
    step();
    check("p1_strobe", 32'(byte_strobe), 32'd1);
    check("p1_done", 32'(tx_done), 32'd1);
    check("p1_cnt", 32'(pkt_cnt), 32'd1);
    gap_then_grant("p1");

    // Counter wrap: preload as if 65535 packets had completed
    force dut.pkt_cnt_reg = 16'hFFFF;
    #1;
    release dut.pkt_cnt_reg;
    go = 1'b1; len = 8'd1;
    step();
    go = 1'b0;
    step();
    check("wrap_done", 32'(tx_done), 32'd1);
    check("wrap_cnt", 32'(pkt_cnt), 32'd0);
    gap_then_grant("wrap");

    // Ready withdrawn during GRANT: back to IDLE without an error
    ready = 1'b0;
    step();
    check("withdraw_ena_n", 32'(ena_n), 32'd1);
    check("withdraw_tmo", 32'(timeout_err), 32'd0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (timeout_err || !ena_n) seen++;
    end
    check("withdraw_quiet", 32'(seen), 32'd0);

    // BYTE_CYC=3, 2-byte packet: strobes at cycles 3 and 6 after entry
    ready3 = 1'b1;
    step();
    check("b3_grant", 32'(ena_n3), 32'd0);
    go3 = 1'b1; len3 = 8'd2;
    step();
    go3 = 1'b0;
    check("b3_busy0", 32'(link_busy3), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("b3_strobe_c%0d", k), 32'(byte_strobe3),
            (k == 3 || k == 6) ? 32'd1 : 32'd0);
      check($sformatf("b3_busy_c%0d", k), 32'(link_busy3), (k < 6) ? 32'd1 : 32'd0);
    end
    check("b3_done", 32'(tx_done3), 32'd1);
    check("b3_cnt", 32'(pkt_cnt3), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
